// File: rtl/mux_16to1_pkg.sv
// Shared constants and types for the registered 16:1 word multiplexer.
package mux_16to1_pkg;

  localparam int NUM_IN        = 16;
  localparam int SEL_W         = 4;
  localparam int DEFAULT_WIDTH = 16;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_4to1.sv
// Combinational 4:1 word mux; the leaf of the 16:1 select tree.
module mux_4to1 #(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux_16to1.sv
// Registered 16:1 word mux with load enable and valid flag.
// Optional even-parity output when MUX16TO1_PARITY_EN is defined.
module mux_16to1
  import mux_16to1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  sel_t             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic [WIDTH-1:0] d8,
  input  logic [WIDTH-1:0] d9,
  input  logic [WIDTH-1:0] d10,
  input  logic [WIDTH-1:0] d11,
  input  logic [WIDTH-1:0] d12,
  input  logic [WIDTH-1:0] d13,
  input  logic [WIDTH-1:0] d14,
  input  logic [WIDTH-1:0] d15,
`ifdef MUX16TO1_PARITY_EN
  output logic             dout_par,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  logic [WIDTH-1:0] d [NUM_IN];
  logic [WIDTH-1:0] rank1 [4];
  logic [WIDTH-1:0] mux_word;

  assign d[0]  = d0;
  assign d[1]  = d1;
  assign d[2]  = d2;
  assign d[3]  = d3;
  assign d[4]  = d4;
  assign d[5]  = d5;
  assign d[6]  = d6;
  assign d[7]  = d7;
  assign d[8]  = d8;
  assign d[9]  = d9;
  assign d[10] = d10;
  assign d[11] = d11;
  assign d[12] = d12;
  assign d[13] = d13;
  assign d[14] = d14;
  assign d[15] = d15;

  // First rank resolves sel[1:0] within each group of four inputs.
  for (genvar g = 0; g < 4; g++) begin : g_rank1
    mux_4to1 #(.WIDTH(WIDTH)) u_mux (
      .sel (sel[1:0]),
      .d0  (d[4*g]),
      .d1  (d[4*g+1]),
      .d2  (d[4*g+2]),
      .d3  (d[4*g+3]),
      .y   (rank1[g])
    );
  end

  mux_4to1 #(.WIDTH(WIDTH)) u_rank2 (
    .sel (sel[3:2]),
    .d0  (rank1[0]),
    .d1  (rank1[1]),
    .d2  (rank1[2]),
    .d3  (rank1[3]),
    .y   (mux_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (en) begin
      dout       <= mux_word;
      dout_valid <= 1'b1;
    end else begin
      dout_valid <= 1'b0;
    end
  end

`ifdef MUX16TO1_PARITY_EN
  // Parity is computed from the mux output so it lands in the same cycle as dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_par <= 1'b0;
    end else if (en) begin
      dout_par <= ^mux_word;
    end
  end
`endif

endmodule

// File: tb/tb_mux_16to1.sv
// Directed self-checking bench for mux_16to1 (parity checks when MUX16TO1_PARITY_EN is defined).
module tb_mux_16to1;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [3:0]   sel;
  logic [W-1:0] dv [16];
  logic [W-1:0] dout;
  logic         dout_valid;
`ifdef MUX16TO1_PARITY_EN
  logic         dout_par;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_16to1 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sel        (sel),
    .d0         (dv[0]),
    .d1         (dv[1]),
    .d2         (dv[2]),
    .d3         (dv[3]),
    .d4         (dv[4]),
    .d5         (dv[5]),
    .d6         (dv[6]),
    .d7         (dv[7]),
    .d8         (dv[8]),
    .d9         (dv[9]),
    .d10        (dv[10]),
    .d11        (dv[11]),
    .d12        (dv[12]),
    .d13        (dv[13]),
    .d14        (dv[14]),
    .d15        (dv[15]),
`ifdef MUX16TO1_PARITY_EN
    .dout_par   (dout_par),
`endif
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_index_data();
    for (int i = 0; i < 16; i++) dv[i] = W'(i);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    sel = 4'd5;
    load_index_data();

    // Reset held two cycles with en high
    tick();
    check("rst1_dout", 32'(dout), 32'h0);
    check("rst1_valid", 32'(dout_valid), 32'h0);
`ifdef MUX16TO1_PARITY_EN
    check("rst1_par", 32'(dout_par), 32'h0);
`endif
    tick();
    check("rst2_dout", 32'(dout), 32'h0);
    check("rst2_valid", 32'(dout_valid), 32'h0);
    rst = 1'b0;
    tick();
    check("first_load_dout", 32'(dout), 32'd5);
    check("first_load_valid", 32'(dout_valid), 32'h1);

    // Select sweep 0..8
    for (int s = 0; s <= 8; s++) begin
      sel = 4'(s);
      tick();
      check($sformatf("sweep%0d_dout", s), 32'(dout), 32'(s));
      check($sformatf("sweep%0d_valid", s), 32'(dout_valid), 32'h1);
    end

    // Boundary encodings
    for (int i = 0; i < 16; i++) dv[i] = 16'hA5A0 + W'(i);
    sel = 4'd15;
    tick();
    check("sel15", 32'(dout), 32'h0000A5AF);
    sel = 4'd0;
    tick();
    check("sel0", 32'(dout), 32'h0000A5A0);

    // Hold with en low
    load_index_data();
    sel = 4'd7;
    tick();
    check("hold_load", 32'(dout), 32'd7);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel   = 4'(i + 9);
      dv[7] = 16'hFFF0 + W'(i);
      tick();
      check($sformatf("hold%0d_dout", i), 32'(dout), 32'd7);
      check($sformatf("hold%0d_valid", i), 32'(dout_valid), 32'h0);
    end

    // One-cycle reset mid-stream
    load_index_data();
    en  = 1'b1;
    sel = 4'd2;
    tick();
    check("mid_pre", 32'(dout), 32'd2);
    sel = 4'd3;
    rst = 1'b1;
    tick();
    check("mid_rst_dout", 32'(dout), 32'h0);
    check("mid_rst_valid", 32'(dout_valid), 32'h0);
    rst = 1'b0;
    sel = 4'd4;
    tick();
    check("mid_resume_dout", 32'(dout), 32'd4);
    check("mid_resume_valid", 32'(dout_valid), 32'h1);
    sel = 4'd12;
    tick();
    check("mid_resume2", 32'(dout), 32'd12);

`ifdef MUX16TO1_PARITY_EN
    dv[3] = 16'h0007;
    dv[4] = 16'h0003;
    sel   = 4'd3;
    tick();
    check("par_odd", 32'(dout_par), 32'h1);
    sel = 4'd4;
    tick();
    check("par_even", 32'(dout_par), 32'h0);
    en  = 1'b0;
    sel = 4'd3;
    tick();
    check("par_hold", 32'(dout_par), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
